mult_seq_controller: RTL and testbench

//  Control-unit FSM that sequences the 8-bit datapath (input mux, X/ACC/CNT registers, add/sub ALU)
//  to compute ACC = X * N by repeated addition. Drives the datapath's control word and reads its status.

---
 rtl/mult_seq_controller_if.sv | 38 +++
 rtl/mult_seq_controller.sv | 130 +++++++++++++
 tb/tb_mult_seq_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_controller_if.sv
// ============================================================================
// mult_seq_controller_if : host/datapath handshake and control-word bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mult_seq_controller_if;
  logic start;
  logic cnt_zero;
  logic in_sel;
  logic alu_a_sel;
  logic alu_b_sel;
  logic alu_sub;
  logic x_load;
  logic cnt_load;
  logic acc_load;
  logic acc_clr;
  logic busy;
  logic done;
  logic err;

  // master = controller, slave = host plus datapath
  modport master (
    input  start, cnt_zero,
    output in_sel, alu_a_sel, alu_b_sel, alu_sub,
    output x_load, cnt_load, acc_load, acc_clr,
    output busy, done, err
  );

  modport slave (
    output start, cnt_zero,
    input  in_sel, alu_a_sel, alu_b_sel, alu_sub,
    input  x_load, cnt_load, acc_load, acc_clr,
    input  busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/mult_seq_controller.sv
// ============================================================================
// mult_seq_controller : Moore FSM sequencing ACC = X * N by repeated addition
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_seq_controller #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  mult_seq_controller_if.master  bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_X = 4'd1;
  localparam logic [3:0] S_LOAD_N = 4'd2;
  localparam logic [3:0] S_CLR    = 4'd3;
  localparam logic [3:0] S_CHECK  = 4'd4;
  localparam logic [3:0] S_ADD    = 4'd5;
  localparam logic [3:0] S_DEC    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  localparam logic [ITER_W-1:0] C_MAX_ITER = ITER_W'(MAX_ITER);

  logic [3:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q,  iter_d;

  always_comb begin
    state_d = S_IDLE;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE:   state_d = bus.start ? S_LOAD_X : S_IDLE;
      S_LOAD_X: state_d = S_LOAD_N;
      S_LOAD_N: state_d = S_CLR;
      S_CLR: begin
        iter_d  = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // cnt_zero wins over the watchdog so an exact final count still completes
        if (bus.cnt_zero)
          state_d = S_DONE;
        else if (iter_q == C_MAX_ITER)
          state_d = S_ERR;
        else
          state_d = S_ADD;
      end
      S_ADD: begin
        iter_d  = iter_q + 1'b1;
        state_d = S_DEC;
      end
      S_DEC:    state_d = S_CHECK;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    bus.in_sel    = 1'b0;
    bus.alu_a_sel = 1'b0;
    bus.alu_b_sel = 1'b0;
    bus.alu_sub   = 1'b0;
    bus.x_load    = 1'b0;
    bus.cnt_load  = 1'b0;
    bus.acc_load  = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    case (state_q)
      S_LOAD_X: begin
        bus.busy   = 1'b1;
        bus.in_sel = 1'b1;
        bus.x_load = 1'b1;
      end
      S_LOAD_N: begin
        bus.busy     = 1'b1;
        bus.in_sel   = 1'b1;
        bus.cnt_load = 1'b1;
      end
      S_CLR: begin
        bus.busy    = 1'b1;
        bus.acc_clr = 1'b1;
      end
      S_CHECK: begin
        bus.busy = 1'b1;
      end
      S_ADD: begin
        bus.busy     = 1'b1;
        bus.acc_load = 1'b1;
      end
      S_DEC: begin
        bus.busy      = 1'b1;
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = 1'b1;
        bus.alu_sub   = 1'b1;
        bus.cnt_load  = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      S_ERR: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_controller.sv
// ============================================================================
// tb_mult_seq_controller : directed bench with a behavioural 8-bit datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_seq_controller;

  localparam logic [10:0] V_IDLE  = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] V_LOADX = 11'b1_0_0_0_1_0_0_0_1_0_0;
  localparam logic [10:0] V_LOADN = 11'b1_0_0_0_0_1_0_0_1_0_0;
  localparam logic [10:0] V_CLR   = 11'b0_0_0_0_0_0_0_1_1_0_0;
  localparam logic [10:0] V_CHECK = 11'b0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [10:0] V_ADD   = 11'b0_0_0_0_0_0_1_0_1_0_0;
  localparam logic [10:0] V_DEC   = 11'b0_1_1_1_0_1_0_0_1_0_0;
  localparam logic [10:0] V_DONE  = 11'b0_0_0_0_0_0_0_0_1_1_0;
  localparam logic [10:0] V_ERR   = 11'b0_0_0_0_0_0_0_0_1_1_1;

  logic clk;
  logic reset;

  mult_seq_controller_if bus_a ();
  mult_seq_controller_if bus_b ();

  mult_seq_controller #(.ITER_W(8), .MAX_ITER(255)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mult_seq_controller #(.ITER_W(8), .MAX_ITER(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model for dut_a: mux, X/CNT/ACC registers, add/sub ALU
  logic [7:0] op_x, op_n;
  logic [7:0] x_q   = 8'd0;
  logic [7:0] cnt_q = 8'd0;
  logic [7:0] acc_q = 8'd0;
  logic [7:0] data_in, alu_a, alu_b, alu_res, mux_out;

  assign data_in       = bus_a.x_load ? op_x : op_n;
  assign alu_a         = bus_a.alu_a_sel ? cnt_q : acc_q;
  assign alu_b         = bus_a.alu_b_sel ? 8'd1 : x_q;
  assign alu_res       = bus_a.alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
  assign mux_out       = bus_a.in_sel ? data_in : alu_res;
  assign bus_a.cnt_zero = (cnt_q == 8'd0);

  always @(posedge clk) begin
    if (bus_a.x_load)   x_q   <= mux_out;
    if (bus_a.cnt_load) cnt_q <= mux_out;
    if (bus_a.acc_clr)       acc_q <= 8'd0;
    else if (bus_a.acc_load) acc_q <= mux_out;
  end

  int done_total_a = 0;
  int accl_total_a = 0;
  int accl_total_b = 0;

  always @(posedge clk) begin
    if (bus_a.done)     done_total_a <= done_total_a + 1;
    if (bus_a.acc_load) accl_total_a <= accl_total_a + 1;
    if (bus_b.acc_load) accl_total_b <= accl_total_b + 1;
  end

  logic [10:0] vec_a, vec_b;
  assign vec_a = {bus_a.in_sel, bus_a.alu_a_sel, bus_a.alu_b_sel, bus_a.alu_sub,
                  bus_a.x_load, bus_a.cnt_load, bus_a.acc_load, bus_a.acc_clr,
                  bus_a.busy, bus_a.done, bus_a.err};
  assign vec_b = {bus_b.in_sel, bus_b.alu_a_sel, bus_b.alu_b_sel, bus_b.alu_sub,
                  bus_b.x_load, bus_b.cnt_load, bus_b.acc_load, bus_b.acc_clr,
                  bus_b.busy, bus_b.done, bus_b.err};

  int checks = 0;
  int errors = 0;
  logic [10:0] trace [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One operation on dut_a; start_at >= 0 re-pulses start during that cycle
  task automatic run(input logic [7:0] x, input logic [7:0] n, input int start_at,
                     output int dcyc, output int bcyc, output logic e);
    int cyc;
    op_x = x;
    op_n = n;
    bus_a.start = 1'b1;
    tick();
    cyc = 1;
    bus_a.start = 1'b0;
    chk("loadx_vec", 32'(vec_a), 32'(V_LOADX));
    dcyc = -1;
    bcyc = 0;
    e    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc < 32) trace[cyc] = vec_a;
      if (bus_a.busy) bcyc++;
      bus_a.start = (cyc == start_at);
      if (bus_a.done) begin
        dcyc = cyc;
        e    = bus_a.err;
        break;
      end
      tick();
      cyc++;
    end
    bus_a.start = 1'b0;
    tick();
    chk("idle_after_done", 32'(vec_a), 32'(V_IDLE));
  endtask

  initial begin
    int dc, bc, d0, l0, cyc, dcb;
    logic e, eb;

    reset        = 1'b1;
    bus_a.start  = 1'b1;
    bus_b.start  = 1'b0;
    bus_b.cnt_zero = 1'b0;
    op_x = 8'd0;
    op_n = 8'd0;

    // Reset held with start high
    tick();
    chk("rst_outs_1", 32'(vec_a), 32'(V_IDLE));
    tick();
    chk("rst_outs_2", 32'(vec_a), 32'(V_IDLE));
    chk("rst_outs_b", 32'(vec_b), 32'(V_IDLE));
    reset = 1'b0;

    // X=7, N=3
    run(8'd7, 8'd3, -1, dc, bc, e);
    chk("t2_done_cyc", 32'(dc), 32'd14);
    chk("t2_err", 32'(e), 32'd0);
    chk("t2_busy_cycles", 32'(bc), 32'd14);
    chk("t2_acc", 32'(acc_q), 32'd21);
    chk("t2_add_vec", 32'(trace[5]), 32'(V_ADD));
    chk("t2_dec_vec", 32'(trace[6]), 32'(V_DEC));

    // N=0: straight to DONE, no accumulation
    l0 = accl_total_a;
    run(8'd5, 8'd0, -1, dc, bc, e);
    chk("t3_done_cyc", 32'(dc), 32'd5);
    chk("t3_loadn_vec", 32'(trace[2]), 32'(V_LOADN));
    chk("t3_clr_vec", 32'(trace[3]), 32'(V_CLR));
    chk("t3_check_vec", 32'(trace[4]), 32'(V_CHECK));
    chk("t3_done_vec", 32'(trace[5]), 32'(V_DONE));
    chk("t3_acc", 32'(acc_q), 32'd0);
    chk("t3_acc_loads", 32'(accl_total_a - l0), 32'd0);

    // start pulsed during an ADD cycle is ignored
    d0 = done_total_a;
    run(8'd2, 8'd5, 8, dc, bc, e);
    chk("t5_done_cyc", 32'(dc), 32'd20);
    chk("t5_acc", 32'(acc_q), 32'd10);
    chk("t5_done_pulses", 32'(done_total_a - d0), 32'd1);

    // Reset during DEC of X=9, N=4 aborts silently
    op_x = 8'd9;
    op_n = 8'd4;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 2; i <= 6; i++) tick();
    chk("t6_dec_vec", 32'(vec_a), 32'(V_DEC));
    d0 = done_total_a;
    reset = 1'b1;
    tick();
    chk("t6_rst_vec", 32'(vec_a), 32'(V_IDLE));
    reset = 1'b0;
    tick();
    chk("t6_idle_vec", 32'(vec_a), 32'(V_IDLE));
    chk("t6_no_done", 32'(done_total_a - d0), 32'd0);
    run(8'd9, 8'd4, -1, dc, bc, e);
    chk("t6_done_cyc", 32'(dc), 32'd17);
    chk("t6_acc", 32'(acc_q), 32'd36);

    // Watchdog on dut_b (MAX_ITER=4, cnt_zero stuck low)
    l0 = accl_total_b;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    cyc = 1;
    dcb = -1;
    eb  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus_b.done) begin
        dcb = cyc;
        eb  = bus_b.err;
        chk("t4_err_vec", 32'(vec_b), 32'(V_ERR));
        break;
      end
      tick();
      cyc++;
    end
    chk("t4_done_cyc", 32'(dcb), 32'd17);
    chk("t4_err", 32'(eb), 32'd1);
    tick();
    chk("t4_idle_vec", 32'(vec_b), 32'(V_IDLE));
    chk("t4_add_pulses", 32'(accl_total_b - l0), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
